// File: rtl/sr_fetch_ctrl.sv
// Fetch sequencer for a fixed-latency instruction memory: issues sequential fetches,
// tracks them in a valid/PC latency pipe and buffers returned words for decode.
module sr_fetch_ctrl #(
    parameter int          IMEM_LATENCY = 2,
    parameter int          DEPTH        = 4,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = 6;
    localparam int LAST  = IMEM_LATENCY - 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(DEPTH);

    logic                    rst_d_r;
    logic [31:0]             fetch_pc_r;
    logic [IMEM_LATENCY-1:0] pipe_vld_r;
    logic [31:0]             pipe_pc_r   [IMEM_LATENCY];
    logic [31:0]             buf_instr_r [DEPTH];
    logic [31:0]             buf_pc_r    [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [CNT_W-1:0]        count_r;

    logic [SUM_W-1:0]        inflight_s;
    logic                    credit_ok_s;
    logic                    issue_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    head_valid_s;

    // Count requests still travelling through the latency pipe.
    always_comb begin
        inflight_s = {SUM_W{1'b0}};
        for (int i = 0; i < IMEM_LATENCY; i++) begin
            inflight_s = inflight_s + {{(SUM_W-1){1'b0}}, pipe_vld_r[i]};
        end
    end

    // Every in-flight request owns a buffer slot, so a return can never overflow.
    assign credit_ok_s  = (SUM_W'(count_r) + inflight_s) < DEPTH_SUM;
    assign issue_s      = !rst && !rst_d_r && credit_ok_s && !redirect;
    assign push_s       = pipe_vld_r[LAST];
    assign head_valid_s = (count_r != {CNT_W{1'b0}}) && !rst;
    assign pop_s        = head_valid_s && instr_ready;

    assign imem_req    = issue_s;
    assign imem_addr   = fetch_pc_r;
    assign instr_valid = head_valid_s;
    assign instr       = buf_instr_r[rd_ptr_r];
    assign instr_pc    = buf_pc_r[rd_ptr_r];

    // Control state: fetch PC, pipe valids and buffer pointers; reset beats redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_d_r    <= 1'b1;
            fetch_pc_r <= RESET_PC;
            pipe_vld_r <= {IMEM_LATENCY{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
        end else if (redirect) begin
            rst_d_r    <= 1'b0;
            fetch_pc_r <= redirect_pc;
            pipe_vld_r <= {IMEM_LATENCY{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
        end else begin
            rst_d_r <= 1'b0;
            if (issue_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            pipe_vld_r[0] <= issue_s;
            for (int i = 1; i < IMEM_LATENCY; i++) begin
                pipe_vld_r[i] <= pipe_vld_r[i-1];
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Datapath: request PCs ride the pipe, returned words land at the write pointer.
    always_ff @(posedge clk) begin
        pipe_pc_r[0] <= fetch_pc_r;
        for (int i = 1; i < IMEM_LATENCY; i++) begin
            pipe_pc_r[i] <= pipe_pc_r[i-1];
        end
        if (push_s) begin
            buf_instr_r[wr_ptr_r] <= imem_rdata;
            buf_pc_r[wr_ptr_r]    <= pipe_pc_r[LAST];
        end
    end

    sr_fetch_ctrl_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .push        (push_s),
        .count       (count_r),
        .instr_valid (head_valid_s),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

endmodule

// Protocol checker: no buffer overflow and a stalled head must hold still.
module sr_fetch_ctrl_chk #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             push,
    input logic [CNT_W-1:0] count,
    input logic             instr_valid,
    input logic             instr_ready,
    input logic [31:0]      instr,
    input logic [31:0]      instr_pc
);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        push |-> (count < CNT_W'(DEPTH)));

    a_head_stable: assert property (@(posedge clk) disable iff (rst)
        (instr_valid && !instr_ready) |=>
            (!instr_valid || ($stable(instr) && $stable(instr_pc))));

endmodule

// File: tb/tb_sr_fetch_ctrl.sv
// Directed bench for sr_fetch_ctrl: three instances (latency 2, 1, 4) with a
// fixed-latency memory model; each task checks fetch and delivery cycle by cycle.
module tb_sr_fetch_ctrl;

    logic        clk;
    logic [2:0]  rst_v;
    logic [2:0]  redir_v;
    logic [2:0]  ready_v;
    logic [31:0] rpc_v   [3];
    wire  [2:0]  req_v;
    wire  [2:0]  valid_v;
    wire  [31:0] addr_v  [3];
    wire  [31:0] rdata_v [3];
    wire  [31:0] instr_v [3];
    wire  [31:0] pc_v    [3];

    logic        pv [3][8];
    logic [31:0] pa [3][8];

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    sr_fetch_ctrl #(.IMEM_LATENCY(2), .DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut0 (
        .clk(clk), .rst(rst_v[0]), .imem_req(req_v[0]), .imem_addr(addr_v[0]),
        .imem_rdata(rdata_v[0]), .redirect(redir_v[0]), .redirect_pc(rpc_v[0]),
        .instr_valid(valid_v[0]), .instr(instr_v[0]), .instr_pc(pc_v[0]),
        .instr_ready(ready_v[0]));

    sr_fetch_ctrl #(.IMEM_LATENCY(1), .DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .imem_req(req_v[1]), .imem_addr(addr_v[1]),
        .imem_rdata(rdata_v[1]), .redirect(redir_v[1]), .redirect_pc(rpc_v[1]),
        .instr_valid(valid_v[1]), .instr(instr_v[1]), .instr_pc(pc_v[1]),
        .instr_ready(ready_v[1]));

    sr_fetch_ctrl #(.IMEM_LATENCY(4), .DEPTH(4), .RESET_PC(32'h0000_1000)) u_dut2 (
        .clk(clk), .rst(rst_v[2]), .imem_req(req_v[2]), .imem_addr(addr_v[2]),
        .imem_rdata(rdata_v[2]), .redirect(redir_v[2]), .redirect_pc(rpc_v[2]),
        .instr_valid(valid_v[2]), .instr(instr_v[2]), .instr_pc(pc_v[2]),
        .instr_ready(ready_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: remembers each request and answers exactly its latency later.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            for (int j = 7; j > 0; j--) begin
                pv[k][j] <= pv[k][j-1];
                pa[k][j] <= pa[k][j-1];
            end
            pv[k][0] <= req_v[k];
            pa[k][0] <= addr_v[k];
        end
    end

    assign rdata_v[0] = pv[0][1] ? imem_word(pa[0][1]) : 32'hDEAD_BEEF;
    assign rdata_v[1] = pv[1][0] ? imem_word(pa[1][0]) : 32'hDEAD_BEEF;
    assign rdata_v[2] = pv[2][3] ? imem_word(pa[2][3]) : 32'hDEAD_BEEF;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle with rst low (rst_d still high).
    task automatic reset0(input logic rdy);
        rst_v[0]   = 1'b1;
        redir_v[0] = 1'b0;
        ready_v[0] = rdy;
        cyc();
        cyc();
        rst_v[0] = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_v[0] = 1'b1; ready_v[0] = 1'b1; redir_v[0] = 1'b0;
        cyc(); #1;
        checks++;
        if (req_v[0] !== 1'b0 || valid_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got req=%b valid=%b, expected 0 0", req_v[0], valid_v[0]);
        end
        cyc(); rst_v[0] = 1'b0; #1;
        checks++;
        if (req_v[0] !== 1'b0 || valid_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got req=%b valid=%b, expected 0 0", req_v[0], valid_v[0]);
        end
        cyc(); #1;
        checks++;
        if (req_v[0] !== 1'b1 || addr_v[0] !== 32'h0000_0000 || valid_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_fetch: got req=%b addr=%h valid=%b, expected 1 00000000 0",
                     req_v[0], addr_v[0], valid_v[0]);
        end
    endtask

    task automatic test_stream();
        logic e_req, e_v;
        logic [31:0] e_addr, e_pc;
        reset0(1'b1);
        for (int n = 1; n <= 12; n++) begin
            if (n > 1) cyc();
            #1;
            e_req = (n >= 2); e_addr = 32'(4 * (n - 2));
            e_v   = (n >= 5); e_pc   = 32'(4 * (n - 5));
            checks++;
            if (req_v[0] !== e_req || (e_req && addr_v[0] !== e_addr)) begin
                errors++;
                $display("FAIL stream_fetch c%0d: got req=%b addr=%h, expected req=%b addr=%h",
                         n, req_v[0], addr_v[0], e_req, e_addr);
            end
            checks++;
            if (valid_v[0] !== e_v || (e_v && (pc_v[0] !== e_pc || instr_v[0] !== imem_word(e_pc)))) begin
                errors++;
                $display("FAIL stream_deliver c%0d: got valid=%b pc=%h instr=%h, expected valid=%b pc=%h",
                         n, valid_v[0], pc_v[0], instr_v[0], e_v, e_pc);
            end
        end
    endtask

    task automatic test_backpressure();
        logic e_req, e_v;
        logic [31:0] e_addr, e_pc;
        reset0(1'b0);
        for (int n = 1; n <= 14; n++) begin
            if (n > 1) cyc();
            if (n == 10) ready_v[0] = 1'b1;
            #1;
            e_req  = (n >= 2 && n <= 5) || (n >= 11);
            e_addr = (n <= 5) ? 32'(4 * (n - 2)) : 32'(16 + 4 * (n - 11));
            e_v    = (n >= 5);
            e_pc   = (n < 10) ? 32'h0000_0000 : 32'(4 * (n - 10));
            checks++;
            if (req_v[0] !== e_req || (e_req && addr_v[0] !== e_addr)) begin
                errors++;
                $display("FAIL backpressure_fetch c%0d: got req=%b addr=%h, expected req=%b addr=%h",
                         n, req_v[0], addr_v[0], e_req, e_addr);
            end
            checks++;
            if (valid_v[0] !== e_v || (e_v && (pc_v[0] !== e_pc || instr_v[0] !== imem_word(e_pc)))) begin
                errors++;
                $display("FAIL backpressure_deliver c%0d: got valid=%b pc=%h, expected valid=%b pc=%h",
                         n, valid_v[0], pc_v[0], e_v, e_pc);
            end
        end
    endtask

    task automatic test_redirect_full();
        logic e_req, e_v;
        logic [31:0] e_addr, e_pc;
        reset0(1'b0);
        for (int n = 1; n <= 11; n++) begin
            if (n > 1) cyc();
            if (n == 6) begin redir_v[0] = 1'b1; rpc_v[0] = 32'h0000_0100; end
            if (n == 7) redir_v[0] = 1'b0;
            #1;
            e_req  = (n >= 2 && n <= 5) || (n >= 7 && n <= 10);
            e_addr = (n <= 5) ? 32'(4 * (n - 2)) : 32'h0000_0100 + 32'(4 * (n - 7));
            e_v    = (n == 5) || (n == 6) || (n >= 10);
            e_pc   = (n <= 6) ? 32'h0000_0000 : 32'h0000_0100;
            checks++;
            if (req_v[0] !== e_req || (e_req && addr_v[0] !== e_addr)) begin
                errors++;
                $display("FAIL redirect_full_fetch c%0d: got req=%b addr=%h, expected req=%b addr=%h",
                         n, req_v[0], addr_v[0], e_req, e_addr);
            end
            checks++;
            if (valid_v[0] !== e_v || (e_v && (pc_v[0] !== e_pc || instr_v[0] !== imem_word(e_pc)))) begin
                errors++;
                $display("FAIL redirect_full_deliver c%0d: got valid=%b pc=%h, expected valid=%b pc=%h",
                         n, valid_v[0], pc_v[0], e_v, e_pc);
            end
        end
    endtask

    task automatic test_redirect_handshake();
        logic e_req, e_v;
        logic [31:0] e_addr, e_pc;
        reset0(1'b1);
        for (int n = 1; n <= 12; n++) begin
            if (n > 1) cyc();
            if (n == 7) begin redir_v[0] = 1'b1; rpc_v[0] = 32'h0000_0040; end
            if (n == 8) redir_v[0] = 1'b0;
            #1;
            e_req  = (n >= 2) && (n != 7);
            e_addr = (n <= 6) ? 32'(4 * (n - 2)) : 32'h0000_0040 + 32'(4 * (n - 8));
            e_v    = (n >= 5 && n <= 7) || (n >= 11);
            e_pc   = (n <= 7) ? 32'(4 * (n - 5)) : 32'h0000_0040 + 32'(4 * (n - 11));
            checks++;
            if (req_v[0] !== e_req || (e_req && addr_v[0] !== e_addr)) begin
                errors++;
                $display("FAIL redirect_hs_fetch c%0d: got req=%b addr=%h, expected req=%b addr=%h",
                         n, req_v[0], addr_v[0], e_req, e_addr);
            end
            checks++;
            if (valid_v[0] !== e_v || (e_v && (pc_v[0] !== e_pc || instr_v[0] !== imem_word(e_pc)))) begin
                errors++;
                $display("FAIL redirect_hs_deliver c%0d: got valid=%b pc=%h, expected valid=%b pc=%h",
                         n, valid_v[0], pc_v[0], e_v, e_pc);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic e_req, e_v;
        logic [31:0] e_addr, e_pc;
        reset0(1'b1);
        for (int n = 1; n <= 12; n++) begin
            if (n > 1) cyc();
            if (n == 6) begin redir_v[0] = 1'b1; rpc_v[0] = 32'h0000_0200; end
            if (n == 7) rpc_v[0] = 32'h0000_0300;
            if (n == 8) redir_v[0] = 1'b0;
            #1;
            e_req  = (n >= 2 && n <= 5) || (n >= 8);
            e_addr = (n <= 5) ? 32'(4 * (n - 2)) : 32'h0000_0300 + 32'(4 * (n - 8));
            e_v    = (n == 5) || (n == 6) || (n >= 11);
            e_pc   = (n <= 6) ? 32'(4 * (n - 5)) : 32'h0000_0300 + 32'(4 * (n - 11));
            checks++;
            if (req_v[0] !== e_req || (e_req && addr_v[0] !== e_addr)) begin
                errors++;
                $display("FAIL b2b_fetch c%0d: got req=%b addr=%h, expected req=%b addr=%h",
                         n, req_v[0], addr_v[0], e_req, e_addr);
            end
            checks++;
            if (valid_v[0] !== e_v || (e_v && (pc_v[0] !== e_pc || instr_v[0] !== imem_word(e_pc)))) begin
                errors++;
                $display("FAIL b2b_deliver c%0d: got valid=%b pc=%h, expected valid=%b pc=%h",
                         n, valid_v[0], pc_v[0], e_v, e_pc);
            end
        end
    endtask

    task automatic test_wrap();
        logic e_req, e_v;
        logic [31:0] e_addr, e_pc;
        reset0(1'b1);
        for (int n = 1; n <= 10; n++) begin
            if (n > 1) cyc();
            if (n == 3) begin redir_v[0] = 1'b1; rpc_v[0] = 32'hFFFF_FFF8; end
            if (n == 4) redir_v[0] = 1'b0;
            #1;
            e_req  = (n == 2) || (n >= 4);
            e_addr = (n == 2) ? 32'h0000_0000 : 32'hFFFF_FFF8 + 32'(4 * (n - 4));
            e_v    = (n >= 7);
            e_pc   = 32'hFFFF_FFF8 + 32'(4 * (n - 7));
            checks++;
            if (req_v[0] !== e_req || (e_req && addr_v[0] !== e_addr)) begin
                errors++;
                $display("FAIL wrap_fetch c%0d: got req=%b addr=%h, expected req=%b addr=%h",
                         n, req_v[0], addr_v[0], e_req, e_addr);
            end
            checks++;
            if (valid_v[0] !== e_v || (e_v && (pc_v[0] !== e_pc || instr_v[0] !== imem_word(e_pc)))) begin
                errors++;
                $display("FAIL wrap_deliver c%0d: got valid=%b pc=%h, expected valid=%b pc=%h",
                         n, valid_v[0], pc_v[0], e_v, e_pc);
            end
        end
    endtask

    task automatic test_reset_priority();
        int lat;
        logic [31:0] rpc;
        reset0(1'b1);
        for (int n = 2; n <= 7; n++) cyc();
        rst_v = 3'b111; redir_v = 3'b111;
        for (int k = 0; k < 3; k++) rpc_v[k] = 32'h0000_0500;
        #1;
        checks++;
        if (req_v[0] !== 1'b0 || valid_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL prio_in_reset: got req=%b valid=%b, expected 0 0", req_v[0], valid_v[0]);
        end
        cyc();
        rst_v = 3'b000; redir_v = 3'b000;
        for (int n = 0; n <= 6; n++) begin
            if (n > 0) cyc();
            #1;
            for (int k = 0; k < 3; k++) begin
                lat = (k == 0) ? 2 : ((k == 1) ? 1 : 4);
                rpc = (k == 2) ? 32'h0000_1000 : 32'h0000_0000;
                if (n <= 1) begin
                    checks++;
                    if (req_v[k] !== (n == 1) || (n == 1 && addr_v[k] !== rpc)) begin
                        errors++;
                        $display("FAIL prio_fetch dut%0d n=%0d: got req=%b addr=%h, expected req=%b addr=%h",
                                 k, n, req_v[k], addr_v[k], (n == 1), rpc);
                    end
                end
                if (n <= lat + 2) begin
                    checks++;
                    if (valid_v[k] !== (n == lat + 2) ||
                        (n == lat + 2 && (pc_v[k] !== rpc || instr_v[k] !== imem_word(rpc)))) begin
                        errors++;
                        $display("FAIL prio_first_valid dut%0d n=%0d: got valid=%b pc=%h, expected valid=%b pc=%h",
                                 k, n, valid_v[k], pc_v[k], (n == lat + 2), rpc);
                    end
                end
            end
        end
    endtask

    initial begin
        rst_v   = 3'b111;
        redir_v = 3'b000;
        ready_v = 3'b111;
        for (int k = 0; k < 3; k++) rpc_v[k] = 32'h0000_0000;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_redirect_handshake();
        test_back_to_back();
        test_wrap();
        test_reset_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
